// File: rtl/spi_cmdq_pkg.sv
// Shared types and helpers for the SPI command queue: FSM state encoding,
// length-field width and the received-word mask.
package spi_cmdq_pkg;

   typedef enum logic [1:0] {
      IDLE,
      ISSUE,
      WAIT_DONE,
      CAPTURE
   } state_t;

   // Widest transfer the mask helper supports.
   localparam int MASK_W = 64;

   // Width of a length field able to hold 0..maxlen.
   function automatic int len_w(input int maxlen);
      return $clog2(maxlen) + 1;
   endfunction

   // Ones in bit positions below len, zeros at and above.
   function automatic logic [MASK_W-1:0] len_mask(input int len);
      logic [MASK_W-1:0] m;
      m = '0;
      for (int i = 0; i < MASK_W; i++) m[i] = (i < len);
      return m;
   endfunction

endpackage

// File: rtl/spi_cmdq_fifo.sv
// Generic synchronous FIFO with extra-MSB pointers; push when full and pop
// when empty are ignored, and the head is read combinationally.
module spi_cmdq_fifo #(
   parameter int WIDTH = 8,
   parameter int DEPTH = 4
) (
   input  logic             clk,
   input  logic             sresetn,
   input  logic             push,
   input  logic [WIDTH-1:0] push_data,
   input  logic             pop,
   output logic [WIDTH-1:0] head,
   output logic             empty,
   output logic             full
);
   localparam int AW = $clog2(DEPTH);

   logic [WIDTH-1:0] mem [DEPTH];
   logic [AW:0]      wr_ptr;
   logic [AW:0]      rd_ptr;

   // NOTE: sequential state is updated with non-blocking assignments only.
   always_ff @(posedge clk) begin
      if (!sresetn) begin
         wr_ptr <= '0;
         rd_ptr <= '0;
      end else begin
         if (push && !full) wr_ptr <= wr_ptr + (AW + 1)'(1);
         if (pop && !empty) rd_ptr <= rd_ptr + (AW + 1)'(1);
      end
   end

   // NOTE: the storage array is not reset; the pointers alone decide which entries are valid.
   always_ff @(posedge clk) begin
      if (push && !full) mem[wr_ptr[AW-1:0]] <= push_data;
   end

   assign head  = mem[rd_ptr[AW-1:0]];
   assign empty = (wr_ptr == rd_ptr);
   assign full  = (wr_ptr[AW] != rd_ptr[AW]) && (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]);

endmodule

// File: rtl/spi_cmd_queue.sv
// Command queue in front of spi_drv: buffers commands, issues them one at a time and
// returns masked MISO words. Build macro SPI_CMDQ_TIMEOUT_EN adds the start-ack timeout.
module spi_cmd_queue
   import spi_cmdq_pkg::*;
#(
   parameter  int SPI_MAXLEN = 32,
   parameter  int DEPTH      = 4,
   parameter  int TIMEOUT    = 1024,
   localparam int LW         = len_w(SPI_MAXLEN)
) (
   input  logic                  clk,
   input  logic                  sresetn,
   input  logic                  cmd_valid,
   output logic                  cmd_ready,
   input  logic [LW-1:0]         cmd_len,
   input  logic [SPI_MAXLEN-1:0] cmd_data,
   output logic                  rsp_valid,
   input  logic                  rsp_ready,
   output logic [SPI_MAXLEN-1:0] rsp_data,
   output logic                  rsp_err,
   output logic                  drv_start_cmd,
   input  logic                  drv_rdy,
   output logic [LW-1:0]         drv_n_clks,
   output logic [SPI_MAXLEN-1:0] drv_tx_data,
   input  logic [SPI_MAXLEN-1:0] drv_rx_miso,
   output logic                  busy
);
   localparam int CMD_W = LW + SPI_MAXLEN;
`ifdef SPI_CMDQ_TIMEOUT_EN
   localparam int RSP_W = SPI_MAXLEN + 1;
`else
   localparam int RSP_W = SPI_MAXLEN;
`endif

   if (DEPTH < 2 || (DEPTH & (DEPTH - 1)) != 0 || SPI_MAXLEN < 1 ||
       SPI_MAXLEN > MASK_W || TIMEOUT < 1) begin : g_bad_params
      $error("spi_cmd_queue: illegal parameter set");
   end

   state_t                state;
   logic                  run;
   logic                  cmd_empty, cmd_full, rsp_empty, rsp_full;
   logic                  cmd_pop, rsp_push;
   logic                  go_issue, go_bypass, tmo_hit;
   logic [CMD_W-1:0]      cmd_head;
   logic [LW-1:0]         head_len;
   logic [LW-1:0]         len_q;
   logic [SPI_MAXLEN-1:0] head_data;
   logic [SPI_MAXLEN-1:0] rsp_word;
   logic [RSP_W-1:0]      rsp_in;
   logic [RSP_W-1:0]      rsp_head;

   spi_cmdq_fifo #(.WIDTH(CMD_W), .DEPTH(DEPTH)) u_cmd_fifo (
      .clk       (clk),
      .sresetn   (sresetn),
      .push      (cmd_valid && cmd_ready),
      .push_data ({cmd_len, cmd_data}),
      .pop       (cmd_pop),
      .head      (cmd_head),
      .empty     (cmd_empty),
      .full      (cmd_full)
   );

   spi_cmdq_fifo #(.WIDTH(RSP_W), .DEPTH(DEPTH)) u_rsp_fifo (
      .clk       (clk),
      .sresetn   (sresetn),
      .push      (rsp_push),
      .push_data (rsp_in),
      .pop       (rsp_valid && rsp_ready),
      .head      (rsp_head),
      .empty     (rsp_empty),
      .full      (rsp_full)
   );

   assign {head_len, head_data} = cmd_head;

   // Only one command is ever in flight, so "rsp not full" at launch is the credit.
   assign go_bypass = !cmd_empty && !rsp_full && (head_len == '0);
   assign go_issue  = !cmd_empty && !rsp_full && (head_len != '0) && drv_rdy;

`ifdef SPI_CMDQ_TIMEOUT_EN
   localparam int TW = $clog2(TIMEOUT + 1);
   logic [TW-1:0] tmo_cnt;

   assign tmo_hit = (state == ISSUE) && drv_rdy && (tmo_cnt == TW'(TIMEOUT - 1));

   always_ff @(posedge clk) begin
      if (!sresetn || state != ISSUE) tmo_cnt <= '0;
      else if (drv_rdy)               tmo_cnt <= tmo_cnt + TW'(1);
   end
`else
   assign tmo_hit = 1'b0;
`endif

   always_comb begin
      // NOTE: every signal driven here gets a default first so no latch is inferred.
      cmd_pop  = 1'b0;
      rsp_push = 1'b0;
      rsp_word = '0;
      case (state)
         IDLE:    cmd_pop = go_bypass;
         ISSUE: begin
            cmd_pop  = !drv_rdy || tmo_hit;
            rsp_push = tmo_hit;
         end
         CAPTURE: begin
            rsp_push = 1'b1;
            rsp_word = drv_rx_miso & SPI_MAXLEN'(len_mask(int'(len_q)));
         end
         default: ;
      endcase
   end

`ifdef SPI_CMDQ_TIMEOUT_EN
   assign rsp_in   = {tmo_hit, rsp_word};
   assign rsp_err  = rsp_valid && rsp_head[SPI_MAXLEN];
   assign rsp_data = rsp_valid ? rsp_head[SPI_MAXLEN-1:0] : '0;
`else
   assign rsp_in   = rsp_word;
   assign rsp_err  = 1'b0;
   assign rsp_data = rsp_valid ? rsp_head : '0;
`endif

   assign rsp_valid = !rsp_empty;
   assign cmd_ready = run && !cmd_full;
   assign busy      = !cmd_empty || (state != IDLE) || !rsp_empty;

   always_ff @(posedge clk) begin
      if (!sresetn) begin
         state         <= IDLE;
         run           <= 1'b0;
         drv_start_cmd <= 1'b0;
         drv_n_clks    <= '0;
         drv_tx_data   <= '0;
         len_q         <= '0;
      end else begin
         run <= 1'b1;
         case (state)
            IDLE: begin
               if (go_bypass) begin
                  state <= CAPTURE;
                  len_q <= '0;
               end else if (go_issue) begin
                  state         <= ISSUE;
                  drv_start_cmd <= 1'b1;
                  drv_n_clks    <= head_len;
                  drv_tx_data   <= head_data;
                  len_q         <= head_len;
               end
            end
            ISSUE: begin
               if (!drv_rdy || tmo_hit) begin
                  state         <= drv_rdy ? IDLE : WAIT_DONE;
                  drv_start_cmd <= 1'b0;
                  drv_n_clks    <= '0;
                  drv_tx_data   <= '0;
               end
            end
            WAIT_DONE: if (drv_rdy) state <= CAPTURE;
            CAPTURE:   state <= IDLE;
            default:   state <= IDLE;
         endcase
      end
   end

endmodule

// File: tb/tb_spi_cmd_queue.sv
// Scoreboard bench for spi_cmd_queue with a behavioural spi_drv model; the timeout
// scenario runs only when SPI_CMDQ_TIMEOUT_EN is defined for the build.
module tb_spi_cmd_queue;
   localparam int MAXLEN  = 32;
   localparam int DEPTH   = 4;
   localparam int TIMEOUT = 16;
   localparam int LW      = $clog2(MAXLEN) + 1;

   logic              clk = 1'b0;
   logic              sresetn;
   logic              cmd_valid;
   logic              cmd_ready;
   logic [LW-1:0]     cmd_len;
   logic [MAXLEN-1:0] cmd_data;
   logic              rsp_valid;
   logic              rsp_ready;
   logic [MAXLEN-1:0] rsp_data;
   logic              rsp_err;
   logic              drv_start_cmd;
   logic              drv_rdy;
   logic [LW-1:0]     drv_n_clks;
   logic [MAXLEN-1:0] drv_tx_data;
   logic [MAXLEN-1:0] drv_rx_miso;
   logic              busy;

   always #5 clk = ~clk;

   spi_cmd_queue #(.SPI_MAXLEN(MAXLEN), .DEPTH(DEPTH), .TIMEOUT(TIMEOUT)) dut (
      .clk           (clk),
      .sresetn       (sresetn),
      .cmd_valid     (cmd_valid),
      .cmd_ready     (cmd_ready),
      .cmd_len       (cmd_len),
      .cmd_data      (cmd_data),
      .rsp_valid     (rsp_valid),
      .rsp_ready     (rsp_ready),
      .rsp_data      (rsp_data),
      .rsp_err       (rsp_err),
      .drv_start_cmd (drv_start_cmd),
      .drv_rdy       (drv_rdy),
      .drv_n_clks    (drv_n_clks),
      .drv_tx_data   (drv_tx_data),
      .drv_rx_miso   (drv_rx_miso),
      .busy          (busy)
   );

   int n_checks = 0;
   int n_errors = 0;
   int start_cnt = 0;

   logic [MAXLEN:0]        exp_q  [$];  // {err, data} in delivery order
   logic [LW+MAXLEN-1:0]   drv_q  [$];  // {len, data} expected at the driver
   logic [MAXLEN-1:0]      miso_q [$];  // word the model slave returns

   bit drv_offline = 1'b0;  // driver ready held low
   bit drv_ignore  = 1'b0;  // driver never acknowledges a start
   bit drv_hold    = 1'b0;  // driver stays busy until released
   bit rsp_rand    = 1'b0;
   bit rsp_force   = 1'b0;

   task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_errors++;
         $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
      end
   endtask

   // Reference: the low len bits of the slave word, nothing above.
   function automatic logic [MAXLEN-1:0] model_rsp(input int len, input logic [MAXLEN-1:0] miso);
      longint unsigned w;
      w = 64'(miso);
      return MAXLEN'(w % (64'd1 << len));
   endfunction

   task automatic send(input int len, input logic [MAXLEN-1:0] data,
                       input logic [MAXLEN-1:0] miso, input bit expect_tmo);
      int guard = 0;
      while (!cmd_ready && guard < 2000) begin
         @(posedge clk); #1;
         guard++;
      end
      if (!cmd_ready) begin
         check("cmd_ready_wait", cmd_ready, 1);
         return;
      end
      cmd_valid = 1'b1;
      cmd_len   = LW'(len);
      cmd_data  = data;
      if (expect_tmo) begin
         exp_q.push_back({1'b1, {MAXLEN{1'b0}}});
      end else begin
         exp_q.push_back({1'b0, model_rsp(len, miso)});
         if (len != 0) begin
            drv_q.push_back({LW'(len), data});
            miso_q.push_back(miso);
         end
      end
      @(posedge clk); #1;
      cmd_valid = 1'b0;
      cmd_len   = '0;
      cmd_data  = '0;
   endtask

   task automatic drain(input int max_cyc);
      int c = 0;
      while ((exp_q.size() != 0 || busy) && c < max_cyc) begin
         @(posedge clk); #1;
         c++;
      end
      check("drain_pending", exp_q.size(), 0);
      check("drain_busy", busy, 0);
   endtask

   always @(posedge clk) if (drv_start_cmd) start_cnt <= start_cnt + 1;

   initial begin
      forever begin
         @(posedge clk); #1;
         rsp_ready = rsp_rand ? ($urandom_range(0, 3) != 0) : rsp_force;
      end
   end

   // Response monitor: whatever the DUT hands over must be the next expected entry.
   initial begin
      logic [MAXLEN:0] e;
      forever begin
         @(negedge clk);
         if (sresetn === 1'b1 && rsp_valid && rsp_ready) begin
            if (exp_q.size() == 0) begin
               n_checks++;
               n_errors++;
               $display("FAIL rsp_unexpected: got err=%0b data=0x%0h with nothing expected", rsp_err, rsp_data);
            end else begin
               e = exp_q.pop_front();
               check("rsp", {rsp_err, rsp_data}, e);
            end
         end
      end
   end

   // Behavioural spi_drv: ready idles high, falls one cycle after a start, rises with MISO.
   initial begin
      logic [LW+MAXLEN-1:0] cmd;
      logic [MAXLEN-1:0]    miso;
      int                   busy_cyc;
      drv_rdy     = 1'b0;
      drv_rx_miso = '0;
      forever begin
         @(negedge clk);
         if (sresetn !== 1'b1 || drv_offline) begin
            drv_rdy = 1'b0;
         end else if (!drv_rdy) begin
            drv_rdy = 1'b1;
         end else if (drv_start_cmd && !drv_ignore) begin
            if (drv_q.size() == 0) begin
               n_checks++;
               n_errors++;
               $display("FAIL drv_unexpected_start: n_clks=%0d tx=0x%0h", drv_n_clks, drv_tx_data);
               miso = '0;
            end else begin
               cmd  = drv_q.pop_front();
               miso = miso_q.pop_front();
               check("drv_cmd", {drv_n_clks, drv_tx_data}, cmd);
            end
            drv_rdy = 1'b0;
            @(negedge clk);
            check("drv_start_drop", {drv_start_cmd, drv_n_clks, drv_tx_data}, 0);
            busy_cyc = $urandom_range(0, 3);
            while ((busy_cyc > 0 || drv_hold) && sresetn === 1'b1) begin
               drv_rx_miso = $urandom;
               busy_cyc--;
               @(negedge clk);
            end
            drv_rx_miso = miso;
            drv_rdy     = 1'b1;
         end
      end
   end

   initial begin
      #500000;
      $display("FAIL watchdog: time limit reached with errors=%0d of %0d checks", n_errors, n_checks);
      $fatal(1, "watchdog expired");
   end

   initial begin
      int s;
      int c;
      sresetn   = 1'b0;
      cmd_valid = 1'b0;
      cmd_len   = '0;
      cmd_data  = '0;
      repeat (3) @(posedge clk);
      #1;
      check("reset_cmd_ready", cmd_ready, 0);
      check("reset_rsp_valid", rsp_valid, 0);
      check("reset_busy", busy, 0);
      check("reset_drv_outs", {drv_start_cmd, drv_n_clks, drv_tx_data}, 0);
      check("reset_rsp_outs", {rsp_err, rsp_data}, 0);
      sresetn = 1'b1;
      @(posedge clk); #1;
      check("ready_after_release", cmd_ready, 1);
      rsp_force = 1'b1;
      repeat (2) @(posedge clk);
      #1;

      // Single command with minimum-latency start.
      send(8, 32'h0000_00A5, 32'h0000_003C, 1'b0);
      check("start_not_early", drv_start_cmd, 0);
      @(posedge clk); #1;
      check("start_at_n1", {drv_start_cmd, drv_n_clks, drv_tx_data}, {1'b1, 6'd8, 32'h0000_00A5});
      drain(100);

      // Fill the command FIFO with the driver offline, then the response FIFO.
      drv_offline = 1'b1;
      rsp_force   = 1'b0;
      repeat (2) @(posedge clk);
      #1;
      send(4,  $urandom, $urandom, 1'b0);
      send(16, $urandom, $urandom, 1'b0);
      send(32, $urandom, $urandom, 1'b0);
      send(1,  $urandom, $urandom, 1'b0);
      check("cmd_full_ready", cmd_ready, 0);
      drv_offline = 1'b0;
      repeat (60) @(posedge clk);
      #1;
      check("rsp_full_valid", rsp_valid, 1);
      for (int i = 0; i < 4; i++) send($urandom_range(1, 32), $urandom, $urandom, 1'b0);
      s = start_cnt;
      repeat (10) @(posedge clk);
      #1;
      check("no_issue_when_rsp_full", start_cnt, s);
      check("cmd_full_again", cmd_ready, 0);
      check("busy_while_full", busy, 1);
      rsp_force = 1'b1;
      drain(400);

      // Zero-length command bypasses the driver.
      rsp_force = 1'b0;
      repeat (2) @(posedge clk);
      #1;
      s = start_cnt;
      send(0, $urandom, $urandom, 1'b0);
      repeat (2) @(posedge clk);
      #1;
      check("len0_rsp_valid", rsp_valid, 1);
      check("len0_no_start", start_cnt, s);
      rsp_force = 1'b1;
      drain(50);

      // Upper bits masked.
      send(5, $urandom, 32'hFFFF_FFFF, 1'b0);
      drain(50);

      // Reset while waiting for the driver, with a second command queued behind.
      drv_hold = 1'b1;
      send(12, $urandom, $urandom, 1'b0);
      c = 0;
      while (!(drv_rdy == 1'b0 && drv_start_cmd == 1'b0 && start_cnt > s) && c < 20) begin
         @(posedge clk); #1;
         c++;
      end
      check("reached_wait_done", drv_rdy, 0);
      send(20, $urandom, $urandom, 1'b0);
      sresetn = 1'b0;
      @(posedge clk); #1;
      check("midreset_drv_outs", {drv_start_cmd, drv_n_clks, drv_tx_data}, 0);
      check("midreset_flags", {cmd_ready, rsp_valid, busy}, 0);
      exp_q.delete();
      drv_q.delete();
      miso_q.delete();
      drv_hold = 1'b0;
      @(posedge clk); #1;
      sresetn = 1'b1;
      repeat (6) @(posedge clk);
      #1;
      check("flushed_no_rsp", {rsp_valid, busy}, 0);
      send(24, $urandom, $urandom, 1'b0);
      drain(100);

      // Randomized traffic with a randomly stalling consumer.
      rsp_rand = 1'b1;
      for (int i = 0; i < 40; i++) begin
         send($urandom_range(0, 32), $urandom, $urandom, 1'b0);
         if ($urandom_range(0, 3) == 0) repeat ($urandom_range(1, 8)) @(posedge clk);
         #1;
      end
      rsp_rand = 1'b0;
      drain(2000);

`ifdef SPI_CMDQ_TIMEOUT_EN
      // Driver never acknowledges: start held exactly TIMEOUT cycles, then an error response.
      drv_ignore = 1'b1;
      send(8, $urandom, $urandom, 1'b1);
      c = 0;
      while (!drv_start_cmd && c < 5) begin
         @(posedge clk); #1;
         c++;
      end
      c = 0;
      while (drv_start_cmd && c < 100) begin
         @(posedge clk); #1;
         c++;
      end
      check("timeout_start_cycles", c, TIMEOUT);
      drv_ignore = 1'b0;
      send(9, $urandom, $urandom, 1'b0);
      drain(100);
`endif

      repeat (4) @(posedge clk);
      $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
      $finish;
   end

endmodule
